// File: rtl/guess_checker.sv
// Game-logic stage: draws a secret from a free-running LFSR, converts confirmed BCD
// guesses to binary, and produces the hint, guesses-left count and win/lose status.
module guess_checker #(
    parameter int unsigned MAX_GUESSES = 5,
    parameter logic [9:0]  LFSR_SEED   = 10'h2A5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_round,
    input  logic [1:0] max_digits,
    input  logic       confirm,
    input  logic [3:0] confirm_digit_1,
    input  logic [3:0] confirm_digit_2,
    input  logic [3:0] confirm_digit_3,
    input  logic       timeout,
    output logic [1:0] hint,
    output logic [2:0] guesses_left,
    output logic [1:0] win_lose,
    output logic       ready,
    output logic       result_valid,
    output logic [9:0] secret_dbg
);

    localparam int unsigned VAL_W = 10;
    localparam int unsigned GL_W  = 3;

    localparam logic [1:0] HINT_NONE = 2'b00;
    localparam logic [1:0] HINT_LOW  = 2'b01;
    localparam logic [1:0] HINT_HIGH = 2'b10;
    localparam logic [1:0] HINT_OK   = 2'b11;

    localparam logic [1:0] WL_PLAY = 2'b11;
    localparam logic [1:0] WL_WIN  = 2'b01;
    localparam logic [1:0] WL_LOSE = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAW    = 3'd1,
        READY   = 3'd2,
        CONVERT = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state, state_next;

    logic [VAL_W-1:0] lfsr;
    logic [VAL_W-1:0] candidate_c;
    logic [VAL_W-1:0] limit_c;
    logic [1:0]       digits_q;
    logic [3:0]       d1_q, d2_q, d3_q;
    logic [VAL_W-1:0] guess_bin;
    logic [VAL_W-1:0] conv_c;
    logic [GL_W-1:0]  gl_dec_c;
    logic             draw_hit_c;

    logic [1:0]       hint_n;
    logic [GL_W-1:0]  guesses_left_n;
    logic [1:0]       win_lose_n;
    logic             ready_n;
    logic             result_valid_n;
    logic [VAL_W-1:0] secret_n;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // x^10 + x^7 + 1 Fibonacci LFSR, free-running so the draw depends on user timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end

    assign candidate_c = lfsr - 10'd1;

    always_comb begin
        case (digits_q)
            2'b11:   limit_c = 10'd1000;
            2'b10:   limit_c = 10'd100;
            default: limit_c = 10'd10;
        endcase
    end

    assign draw_hit_c = (candidate_c < limit_c);

    // Only the active low-order digits contribute; out-of-range BCD saturates at 9
    always_comb begin
        case (digits_q)
            2'b11:   conv_c = VAL_W'(clamp9(d1_q)) * 10'd100
                            + VAL_W'(clamp9(d2_q)) * 10'd10
                            + VAL_W'(clamp9(d3_q));
            2'b10:   conv_c = VAL_W'(clamp9(d2_q)) * 10'd10
                            + VAL_W'(clamp9(d3_q));
            default: conv_c = VAL_W'(clamp9(d3_q));
        endcase
    end

    assign gl_dec_c = (guesses_left == '0) ? '0 : guesses_left - GL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (new_round) begin
            state_next = DRAW;
        end else begin
            case (state)
                DRAW: begin
                    if (timeout)         state_next = DONE;
                    else if (draw_hit_c) state_next = READY;
                end
                READY: begin
                    if (timeout)      state_next = DONE;
                    else if (confirm) state_next = CONVERT;
                end
                CONVERT: begin
                    state_next = timeout ? DONE : COMPARE;
                end
                COMPARE: begin
                    if (timeout)                      state_next = DONE;
                    else if (guess_bin == secret_dbg) state_next = DONE;
                    else if (gl_dec_c == '0)          state_next = DONE;
                    else                              state_next = READY;
                end
                default: state_next = state;
            endcase
        end
    end

    // Next values for the registered outputs
    always_comb begin
        hint_n         = hint;
        guesses_left_n = guesses_left;
        win_lose_n     = win_lose;
        secret_n       = secret_dbg;
        result_valid_n = 1'b0;
        ready_n        = (state_next == READY);
        if (new_round) begin
            guesses_left_n = GL_W'(MAX_GUESSES);
            hint_n         = HINT_NONE;
            win_lose_n     = WL_PLAY;
        end else begin
            case (state)
                DRAW: begin
                    if (timeout)         win_lose_n = WL_LOSE;
                    else if (draw_hit_c) secret_n   = candidate_c;
                end
                READY, CONVERT: begin
                    if (timeout) win_lose_n = WL_LOSE;
                end
                COMPARE: begin
                    if (timeout) begin
                        win_lose_n = WL_LOSE;
                    end else begin
                        result_valid_n = 1'b1;
                        if (guess_bin == secret_dbg) begin
                            hint_n     = HINT_OK;
                            win_lose_n = WL_WIN;
                        end else begin
                            hint_n         = (guess_bin < secret_dbg) ? HINT_LOW : HINT_HIGH;
                            guesses_left_n = gl_dec_c;
                            if (gl_dec_c == '0) win_lose_n = WL_LOSE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hint         <= HINT_NONE;
            guesses_left <= '0;
            win_lose     <= WL_PLAY;
            ready        <= 1'b0;
            result_valid <= 1'b0;
            secret_dbg   <= '0;
        end else begin
            hint         <= hint_n;
            guesses_left <= guesses_left_n;
            win_lose     <= win_lose_n;
            ready        <= ready_n;
            result_valid <= result_valid_n;
            secret_dbg   <= secret_n;
        end
    end

    // Round configuration, guess digits and converted guess
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q  <= 2'b01;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            guess_bin <= '0;
        end else begin
            if (new_round) digits_q <= max_digits;
            if (state == READY && confirm && !new_round) begin
                d1_q <= confirm_digit_1;
                d2_q <= confirm_digit_2;
                d3_q <= confirm_digit_3;
            end
            if (state == CONVERT) guess_bin <= conv_c;
        end
    end

endmodule
